// File: rtl/xgriscv_pkg.sv
// xgriscv shared types and constants.
// Fetch entries carry the PC alongside the fetched word.
package xgriscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/xgriscv_ifu_if.sv
// Fetch unit bus: imem port, redirect input and decode handshake.
// master = fetch unit, slave = memory/execute/decode side.
interface xgriscv_ifu_if #(
  parameter int XLEN = 32
);

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic            imem_valid;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            id_ready;
  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_instr;

  modport master (
    output imem_req, imem_addr,
    input  imem_rdata, imem_valid,
    input  redirect_valid, redirect_pc,
    input  id_ready,
    output id_valid, id_pc, id_instr
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_rdata, imem_valid,
    output redirect_valid, redirect_pc,
    output id_ready,
    input  id_valid, id_pc, id_instr
  );

endinterface

// File: rtl/xgriscv_fetch_fifo.sv
// Fetch buffer: synchronous FIFO with flush.
// Head is read straight from the storage registers.
module xgriscv_fetch_fifo
  import xgriscv_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t din,
  output fetch_entry_t dout,
  output logic         empty,
  output logic         full,
  output logic [AW:0]  count
);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          clr;

  assign clr   = rst | flush;
  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign dout  = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count
             + {{AW{1'b0}}, push}
             - {{AW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clr) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!clr) assert (!(push && full && !pop));
  end

endmodule

// File: rtl/xgriscv_ifu.sv
// xgriscv instruction fetch unit: PC, credits, squash.
// Issues fetches only when the buffer can absorb the reply.
module xgriscv_ifu #(
  parameter int XLEN = xgriscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC =
    xgriscv_pkg::RESET_PC_DEFAULT,
  parameter int DEPTH = 2
) (
  input logic           clk,
  input logic           rstn,
  xgriscv_ifu_if.master bus
);

  import xgriscv_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW+1:0] LIMIT = (AW+2)'(DEPTH);
  localparam logic [XLEN-1:0] AMASK = ~XLEN'(3);

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] req_pc;
  logic            inflight;
  logic            squash;
  logic            req;
  logic            push;
  logic            pop;
  logic            empty;
  logic            full;
  logic [AW:0]     count;
  logic [AW+1:0]   occ;
  logic [AW+1:0]   room;
  fetch_entry_t    entry;
  fetch_entry_t    head;

  assign pop  = bus.id_valid & bus.id_ready
              & ~bus.redirect_valid;
  assign occ  = {1'b0, count}
              + {{(AW+1){1'b0}}, inflight};
  assign room = LIMIT + {{(AW+1){1'b0}}, pop};

  // Buffered plus in-flight must stay below DEPTH after this pop.
  assign req = ~rstn & ~bus.redirect_valid
             & (~full | pop) & (occ < room);

  assign push = bus.imem_valid & inflight & ~squash
              & ~rstn & ~bus.redirect_valid;

  assign entry = '{pc: req_pc, instr: bus.imem_rdata};

  always_ff @(posedge clk) begin
    if (rstn) begin
      pc       <= RESET_PC;
      req_pc   <= '0;
      inflight <= 1'b0;
      squash   <= 1'b0;
    end else if (bus.redirect_valid) begin
      pc       <= bus.redirect_pc & AMASK;
      inflight <= 1'b0;
      squash   <= inflight;
    end else begin
      if (req) begin
        pc     <= pc + XLEN'(4);
        req_pc <= pc;
      end
      inflight <= req;
      squash   <= 1'b0;
    end
  end

  xgriscv_fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rstn),
    .flush (bus.redirect_valid),
    .push  (push),
    .pop   (pop),
    .din   (entry),
    .dout  (head),
    .empty (empty),
    .full  (full),
    .count (count)
  );

  assign bus.imem_req  = req;
  assign bus.imem_addr = pc & AMASK;
  assign bus.id_valid  = ~empty & ~rstn;
  assign bus.id_pc     = rstn ? '0 : head.pc;
  assign bus.id_instr  = rstn ? '0 : head.instr;

endmodule

// File: tb/tb_xgriscv_ifu.sv
// Bench for xgriscv_ifu: program-order stream model,
// fixed scenarios plus randomized ready/redirect traffic.
module tb_xgriscv_ifu;

  import xgriscv_pkg::*;

  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

  logic clk = 1'b0;
  logic rstn = 1'b1;
  logic inject = 1'b0;

  always #5 clk = ~clk;

  xgriscv_ifu_if #(.XLEN(32)) b();
  xgriscv_ifu_if #(.XLEN(32)) w();

  xgriscv_ifu u_dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (b)
  );

  xgriscv_ifu #(
    .RESET_PC (WRAP_PC)
  ) u_wrap (
    .clk  (clk),
    .rstn (rstn),
    .bus  (w)
  );

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, a[31:16]} + 32'h13;
  endfunction

  // 1-cycle memory; inject forces a stray response next cycle.
  always @(posedge clk) begin
    b.imem_valid <= b.imem_req | inject;
    b.imem_rdata <= inject ? 32'hDEAD_BEEF : mdata(b.imem_addr);
    w.imem_valid <= w.imem_req;
    w.imem_rdata <= mdata(w.imem_addr);
  end

  int checks = 0;
  int errors = 0;
  int occ = 0;
  int delivered = 0;
  logic [31:0] exp_pc = 32'h0;
  logic [31:0] exp_addr = 32'h0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance the in-order fetch/delivery model by one cycle.
  task automatic model_update();
    if (rstn) begin
      exp_pc = 32'h0;
      exp_addr = 32'h0;
      occ = 0;
    end else if (b.redirect_valid) begin
      exp_pc = b.redirect_pc & ~32'h3;
      exp_addr = exp_pc;
      occ = 0;
    end else begin
      if (b.imem_req) begin
        exp_addr += 32'd4;
        occ++;
      end
      if (b.id_valid && b.id_ready) begin
        exp_pc += 32'd4;
        occ--;
        delivered++;
      end
    end
    tick();
  endtask

  task automatic test_reset();
    rstn = 1'b1;
    b.id_ready = 1'b1;
    b.redirect_valid = 1'b0;
    b.redirect_pc = '0;
    w.id_ready = 1'b1;
    w.redirect_valid = 1'b0;
    w.redirect_pc = '0;
    tick();
    tick();
    @(negedge clk);
    checks++;
    if (b.imem_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_req: got %b want 0", b.imem_req);
    end
    checks++;
    if (b.id_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid: got %b want 0", b.id_valid);
    end
    checks++;
    if (b.id_pc !== 32'h0) begin
      errors++;
      $display("FAIL reset_pc: got %h want 0", b.id_pc);
    end
    checks++;
    if (b.id_instr !== 32'h0) begin
      errors++;
      $display("FAIL reset_instr: got %h want 0", b.id_instr);
    end
    model_update();
  endtask

  task automatic test_stream();
    rstn = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checks++;
      if (b.imem_req !== 1'b1) begin
        errors++;
        $display("FAIL stream_req: cyc %0d got %b want 1", i, b.imem_req);
      end
      checks++;
      if (b.id_valid !== (i >= 2)) begin
        errors++;
        $display("FAIL stream_valid: cyc %0d got %b want %b",
                 i, b.id_valid, (i >= 2));
      end
      if (b.imem_req) begin
        checks++;
        if (b.imem_addr !== exp_addr) begin
          errors++;
          $display("FAIL stream_addr: got %h want %h", b.imem_addr, exp_addr);
        end
      end
      if (b.id_valid) begin
        checks++;
        if (b.id_pc !== exp_pc || b.id_instr !== mdata(exp_pc)) begin
          errors++;
          $display("FAIL stream_head: got %h/%h want %h/%h",
                   b.id_pc, b.id_instr, exp_pc, mdata(exp_pc));
        end
      end
      model_update();
    end
  endtask

  task automatic test_stall();
    b.id_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (b.imem_req !== 1'b0) begin
        errors++;
        $display("FAIL stall_req: cyc %0d got %b want 0", i, b.imem_req);
      end
      checks++;
      if (b.id_valid !== 1'b1 || b.id_pc !== exp_pc
          || b.id_instr !== mdata(exp_pc)) begin
        errors++;
        $display("FAIL stall_hold: got %b %h/%h want 1 %h/%h",
                 b.id_valid, b.id_pc, b.id_instr, exp_pc, mdata(exp_pc));
      end
      model_update();
      checks++;
      if (occ > 2) begin
        errors++;
        $display("FAIL stall_occ: got %0d want <=2", occ);
      end
    end
    b.id_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (b.id_valid !== 1'b1) begin
        errors++;
        $display("FAIL resume_valid: cyc %0d got %b want 1", i, b.id_valid);
      end
      if (b.imem_req) begin
        checks++;
        if (b.imem_addr !== exp_addr) begin
          errors++;
          $display("FAIL resume_addr: got %h want %h", b.imem_addr, exp_addr);
        end
      end
      if (b.id_valid) begin
        checks++;
        if (b.id_pc !== exp_pc || b.id_instr !== mdata(exp_pc)) begin
          errors++;
          $display("FAIL resume_head: got %h want %h", b.id_pc, exp_pc);
        end
      end
      model_update();
    end
  endtask

  task automatic test_redirect(input logic [31:0] tgt,
                               input logic [31:0] want);
    b.redirect_valid = 1'b1;
    b.redirect_pc = tgt;
    @(negedge clk);
    checks++;
    if (b.imem_req !== 1'b0) begin
      errors++;
      $display("FAIL redir_req: got %b want 0", b.imem_req);
    end
    model_update();
    b.redirect_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      checks++;
      if (b.id_valid !== (i >= 2)) begin
        errors++;
        $display("FAIL redir_valid: cyc %0d got %b want %b",
                 i, b.id_valid, (i >= 2));
      end
      if (i == 0) begin
        checks++;
        if (b.imem_req !== 1'b1 || b.imem_addr !== want) begin
          errors++;
          $display("FAIL redir_addr: got %b %h want 1 %h",
                   b.imem_req, b.imem_addr, want);
        end
      end
      if (b.id_valid) begin
        checks++;
        if (b.id_pc !== exp_pc || b.id_instr !== mdata(exp_pc)) begin
          errors++;
          $display("FAIL redir_head: got %h want %h", b.id_pc, exp_pc);
        end
      end
      model_update();
    end
  endtask

  task automatic test_back_to_back();
    int d0;
    b.redirect_valid = 1'b1;
    b.redirect_pc = 32'h40;
    @(negedge clk);
    checks++;
    if (b.imem_req !== 1'b0) begin
      errors++;
      $display("FAIL b2b_req0: got %b want 0", b.imem_req);
    end
    model_update();
    b.redirect_pc = 32'h80;
    @(negedge clk);
    checks++;
    if (b.imem_req !== 1'b0 || b.id_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_req1: got req %b valid %b want 0 0",
               b.imem_req, b.id_valid);
    end
    model_update();
    b.redirect_valid = 1'b0;
    d0 = delivered;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) begin
        checks++;
        if (b.imem_req !== 1'b1 || b.imem_addr !== 32'h80) begin
          errors++;
          $display("FAIL b2b_addr: got %b %h want 1 00000080",
                   b.imem_req, b.imem_addr);
        end
      end
      if (b.id_valid) begin
        checks++;
        if (b.id_pc !== exp_pc || b.id_instr !== mdata(exp_pc)) begin
          errors++;
          $display("FAIL b2b_head: got %h want %h", b.id_pc, exp_pc);
        end
      end
      model_update();
    end
    checks++;
    if (delivered - d0 != 6 || exp_pc !== 32'h98) begin
      errors++;
      $display("FAIL b2b_count: got %0d next %h want 6 00000098",
               delivered - d0, exp_pc);
    end
  endtask

  task automatic test_random();
    int d0;
    d0 = delivered;
    for (int i = 0; i < 400; i++) begin
      b.id_ready = ($urandom % 4) != 0;
      b.redirect_valid = ($urandom % 20) == 0;
      b.redirect_pc = $urandom & 32'h0000_0FFF;
      @(negedge clk);
      if (b.redirect_valid) begin
        checks++;
        if (b.imem_req !== 1'b0) begin
          errors++;
          $display("FAIL rand_redir_req: got %b want 0", b.imem_req);
        end
      end
      if (b.imem_req) begin
        checks++;
        if (b.imem_addr !== exp_addr) begin
          errors++;
          $display("FAIL rand_addr: got %h want %h", b.imem_addr, exp_addr);
        end
      end
      if (b.id_valid) begin
        checks++;
        if (b.id_pc !== exp_pc || b.id_instr !== mdata(exp_pc)) begin
          errors++;
          $display("FAIL rand_head: got %h/%h want %h/%h",
                   b.id_pc, b.id_instr, exp_pc, mdata(exp_pc));
        end
      end
      model_update();
      checks++;
      if (occ > 2 || occ < 0) begin
        errors++;
        $display("FAIL rand_occ: got %0d want 0..2", occ);
      end
    end
    b.id_ready = 1'b1;
    b.redirect_valid = 1'b0;
    checks++;
    if (delivered - d0 < 100) begin
      errors++;
      $display("FAIL rand_progress: got %0d want >=100", delivered - d0);
    end
  endtask

  task automatic test_reset_mid();
    b.id_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) b.id_ready = 1'b1;
      @(negedge clk);
      if (b.id_valid) begin
        checks++;
        if (b.id_pc !== exp_pc) begin
          errors++;
          $display("FAIL rmid_fill: got %h want %h", b.id_pc, exp_pc);
        end
      end
      model_update();
    end
    rstn = 1'b1;
    inject = 1'b1;
    @(negedge clk);
    checks++;
    if (b.imem_req !== 1'b0 || b.id_valid !== 1'b0
        || b.id_pc !== 32'h0 || b.id_instr !== 32'h0) begin
      errors++;
      $display("FAIL rmid_outs: got %b %b %h %h want 0 0 0 0",
               b.imem_req, b.id_valid, b.id_pc, b.id_instr);
    end
    model_update();
    rstn = 1'b0;
    inject = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (b.id_valid !== (i >= 2)) begin
        errors++;
        $display("FAIL rmid_valid: cyc %0d got %b want %b",
                 i, b.id_valid, (i >= 2));
      end
      checks++;
      if (b.imem_req !== 1'b1 || b.imem_addr !== exp_addr) begin
        errors++;
        $display("FAIL rmid_addr: got %b %h want 1 %h",
                 b.imem_req, b.imem_addr, exp_addr);
      end
      if (b.id_valid) begin
        checks++;
        if (b.id_pc !== exp_pc || b.id_instr !== mdata(exp_pc)) begin
          errors++;
          $display("FAIL rmid_head: got %h want %h", b.id_pc, exp_pc);
        end
      end
      model_update();
    end
  endtask

  task automatic test_wrap();
    logic [31:0] wa;
    logic [31:0] wp;
    rstn = 1'b1;
    tick();
    tick();
    rstn = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      wa = WRAP_PC + 32'(4 * i);
      wp = WRAP_PC + 32'(4 * (i - 2));
      checks++;
      if (w.imem_req !== 1'b1 || w.imem_addr !== wa) begin
        errors++;
        $display("FAIL wrap_addr: got %b %h want 1 %h",
                 w.imem_req, w.imem_addr, wa);
      end
      checks++;
      if (w.id_valid !== (i >= 2)
          || (i >= 2 && w.id_pc !== wp)) begin
        errors++;
        $display("FAIL wrap_head: got %b %h want %b %h",
                 w.id_valid, w.id_pc, (i >= 2), wp);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect(32'h100, 32'h100);
    test_redirect(32'h203, 32'h200);
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/xgriscv_ifu.md
Name: xgriscv_ifu

Overview:
Instruction fetch unit for xgriscv_pipeline. It sits directly upstream of decode.
- Owns the architectural PC and issues word-aligned fetches to a 1-cycle-latency instruction memory.
- Buffers returned instructions in a small FIFO and presents {pc, instr} to the decode stage with a valid/ready handshake.
- Takes redirects (branch/jump/exception) from execute and squashes all wrong-path fetches.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- XLEN, 32, PC and instruction width.
- DEPTH, 2, fetch buffer entries (power of two, >=2).

Ports:
- clk, in, 1, clock; all state updates on its rising edge.
- rstn, in, 1, synchronous reset, active-high: state resets on a rising clk edge while rstn=1.
- imem_req, out, 1, fetch request this cycle.
- imem_addr, out, XLEN, fetch address; word aligned, bits [1:0]=0.
- imem_rdata, in, XLEN, instruction data; valid when imem_valid=1.
- imem_valid, in, 1, response to the request issued in the previous cycle.
- redirect_valid, in, 1, PC redirect from execute.
- redirect_pc, in, XLEN, redirect target; bits [1:0] are forced to 0.
- id_ready, in, 1, decode can accept an instruction.
- id_valid, out, 1, {id_pc, id_instr} valid.
- id_pc, out, XLEN, PC of the presented instruction.
- id_instr, out, XLEN, presented instruction.

Behaviour:
- Reset (rstn=1 at an edge) sets: pc=RESET_PC, FIFO empty, inflight=0, squash=0.
- While rstn=1: imem_req=0, id_valid=0, id_pc=0, id_instr=0.
- Request rule: imem_req=1 when rstn=0, redirect_valid=0, and (count + inflight − pop) < DEPTH, where pop = id_valid & id_ready.
- When a request is issued: imem_addr=pc, then pc<=pc+4 (wraps modulo 2^XLEN), inflight<=1, and the request PC is recorded alongside it.
- Memory latency is exactly 1 cycle:
  - imem_valid in cycle n+1 answers the request from cycle n.
  - If squash=0, the response is pushed as {recorded pc, imem_rdata}.
- Output timing: id_valid/id_pc/id_instr come from the FIFO head, which is registered; there is no memory-to-decode bypass. First instruction appears 2 cycles after its request.
- Throughput: 1 instruction/cycle sustained when id_ready stays 1.
- Handshake:
  - Transfer occurs when id_valid & id_ready.
  - While id_valid=1 and id_ready=0, id_pc/id_instr hold stable.
  - Push and pop in the same cycle are allowed, including when the FIFO is full; count is unchanged.
- Full FIFO: the credit rule prevents requests, so no response is ever dropped for lack of space. A push into a full FIFO without a simultaneous pop is an assertion failure.
- Empty FIFO: id_valid=0. A pop while empty cannot occur.
- Redirect (redirect_valid=1 in cycle n):
  - In cycle n: imem_req=0, and no pop happens even if id_ready=1 (redirect wins).
  - At the edge ending cycle n: FIFO flushed, pc<=redirect_pc.
  - If a request was issued in cycle n−1, squash<=1, so the response arriving in cycle n+1 is dropped; squash clears after that response.
  - In cycle n+1: id_valid=0, and a fetch of redirect_pc is issued.
  - Redirects on consecutive cycles: the last one wins.
- Reset mid-operation: any in-flight response arriving in the cycle after reset is ignored (inflight=0), and the FIFO stays empty.
- Pointers: rd_ptr and wr_ptr are log2(DEPTH) bits and wrap naturally; count is log2(DEPTH)+1 bits.

Decomposition:
- Package xgriscv_pkg:
  - XLEN
  - RESET_PC default
  - INSTR_NOP = 32'h0000_0013
  - fetch-entry typedef {pc, instr}
- Sub-module xgriscv_fetch_fifo: synchronous FIFO with push/pop/flush, full/empty/count, and the registered head output.
- The PC, credit, and squash logic stay in xgriscv_ifu.

Test Plan:
- Reset release, memory returning addr-based data, id_ready=1 → imem_addr sequence 0x0, 0x4, 0x8…; id_valid first rises 2 cycles after the first request with id_pc=0x0; thereafter one instruction per cycle with id_pc incrementing by 4.
- id_ready=0 for 5 cycles from steady state → at most DEPTH=2 entries buffered and imem_req drops to 0; id_pc/id_instr stay stable. On id_ready=1, delivery resumes in order with no gaps or duplicates.
- redirect_valid=1 with redirect_pc=0x100 while a fetch of 0x10 is in flight → the 0x10 response is dropped and the FIFO flushed; next imem_addr=0x100; next id_pc seen is 0x100.
- redirect_pc=0x203 → imem_addr=0x200. Redirects to 0x40 then 0x80 on back-to-back cycles → only 0x80 path instructions are delivered.
- RESET_PC=32'hFFFF_FFF8 → fetch addresses 0xFFFF_FFF8, 0xFFFF_FFFC, then 0x0000_0000.
- rstn=1 asserted while the FIFO holds 2 entries and a response is in flight → next cycle id_valid=0 and imem_req=0; after rstn=0, fetch restarts at RESET_PC and no stale instruction appears.
